// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder controller sharing one full-adder cell over WIDTH cycles
// Optional feature macro: SERIAL_ADDER_OVF_EN (adds the signed-overflow flag; default build ties ovf to 0)
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready    operand handshake; a, b, cin captured on acceptance (IDLE only)
//   out_valid/out_ready  result handshake; sum, cout (and ovf) held in DONE until accepted
//   busy                 high while the serial addition runs
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic             ovf
);
    localparam int CW = $clog2(WIDTH) + 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_sha, r_shb, r_sum;
    logic [CW-1:0]    r_cnt;
    logic             r_carry, r_cout;
    logic             w_fa_s, w_fa_co, w_last, w_accept;
    // Shared full-adder cell, fed from the operand LSBs and the carry flop
    assign w_fa_s   = r_sha[0] ^ r_shb[0] ^ r_carry;
    assign w_fa_co  = (r_sha[0] & r_shb[0]) | (r_carry & (r_sha[0] ^ r_shb[0]));
    assign w_last   = r_cnt == CW'(WIDTH - 1);
    assign w_accept = in_valid & in_ready;
    assign sum      = r_sum;
    assign cout     = r_cout;
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                w_next   = in_valid ? RUN : IDLE;
            end
            RUN: begin
                busy   = 1'b1;
                w_next = w_last ? DONE : RUN;
            end
            DONE: begin
                out_valid = 1'b1;
                w_next    = out_ready ? IDLE : DONE;
            end
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_sha   <= '0;
            r_shb   <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_sha   <= a;
                r_shb   <= b;
                r_carry <= cin;
                r_cnt   <= '0;
            end else if (r_state == RUN) begin
                // Sum fills from the MSB so the LSB-first bits land in place after WIDTH shifts
                r_sum   <= (r_sum >> 1) | (WIDTH'(w_fa_s) << (WIDTH - 1));
                r_sha   <= r_sha >> 1;
                r_shb   <= r_shb >> 1;
                r_carry <= w_fa_co;
                r_cnt   <= r_cnt + CW'(1);
                if (w_last) r_cout <= w_fa_co;
            end
        end
    end
`ifdef SERIAL_ADDER_OVF_EN
    logic r_ovf;
    // On the final edge r_carry is the carry into the MSB
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_ovf <= 1'b0;
        else if (r_state == RUN && w_last && !w_accept) r_ovf <= r_carry ^ w_fa_co;
    end
    assign ovf = r_ovf;
`else
    assign ovf = 1'b0;
`endif
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed and random scoreboard bench for serial_adder_ctrl (WIDTH=8)
module tb_serial_adder_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       cin = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] sum;
    logic       cout;
    logic       busy;
    logic       ovf;
    int         total = 0;
    int         bad = 0;
    logic [9:0] q[$];
    serial_adder_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .busy(busy), .ovf(ovf)
    );
    always #5 clk = ~clk;
    // Expected {ovf, cout, sum}; ovf is signed overflow of a+b+cin when enabled
    function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y, input logic c);
        logic [8:0] s;
        logic       ov;
        s  = {1'b0, x} + {1'b0, y} + {8'b0, c};
`ifdef SERIAL_ADDER_OVF_EN
        ov = (x[7] == y[7]) && (s[7] != x[7]);
`else
        ov = 1'b0;
`endif
        return {ov, s};
    endfunction
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask
    task automatic send(input logic [7:0] x, input logic [7:0] y, input logic c);
        int n = 0;
        in_valid = 1'b1;
        a = x;
        b = y;
        cin = c;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", in_ready, 1);
        q.push_back(model(x, y, c));
        @(negedge clk);
        in_valid = 1'b0;
    endtask
    task automatic wait_out(input string tag);
        int n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_out_valid"}, out_valid, 1);
    endtask
    task automatic check_pop(input string tag);
        logic [9:0] e;
        check({tag, "_queue"}, q.size() > 0, 1);
        e = q.size() > 0 ? q.pop_front() : 10'h0;
        check({tag, "_sum"}, sum, e[7:0]);
        check({tag, "_cout"}, cout, e[8]);
        check({tag, "_ovf"}, ovf, e[9]);
    endtask
    task automatic release_out();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask
    task automatic run_op(input string tag, input logic [7:0] x, input logic [7:0] y, input logic c);
        send(x, y, c);
        wait_out(tag);
        check_pop(tag);
        release_out();
    endtask
    initial begin
        int cycles, busy_cnt, issued, done;
        logic [9:0] e;
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_ovf", ovf, 0);
        rst = 1'b0;
        @(negedge clk);
        // 1: basic add with latency and busy-length checks
        send(8'h5A, 8'h3C, 1'b0);
        cycles = 0;
        busy_cnt = 0;
        while (!out_valid && cycles < 100) begin
            if (busy) busy_cnt++;
            cycles++;
            @(negedge clk);
        end
        check("t1_latency", cycles, 8);
        check("t1_busy_len", busy_cnt, 8);
        check("t1_busy_done", busy, 0);
        check("t1_in_ready_done", in_ready, 0);
        check_pop("t1");
        release_out();
        // 2: carry propagation through all bits
        run_op("t2a", 8'hFF, 8'h01, 1'b0);
        run_op("t2b", 8'hFF, 8'h00, 1'b1);
        // 3: backpressure in DONE with ignored input pulses
        send(8'hA5, 8'h5A, 1'b1);
        wait_out("t3");
        e = q[0];
        repeat (5) begin
            in_valid = 1'b1;
            a = 8'h11;
            b = 8'h11;
            @(negedge clk);
            check("t3_hold_valid", out_valid, 1);
            check("t3_hold_sum", sum, e[7:0]);
            check("t3_hold_cout", cout, e[8]);
            check("t3_hold_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        check_pop("t3");
        release_out();
        check("t3_idle_in_ready", in_ready, 1);
        check("t3_idle_out_valid", out_valid, 0);
        @(negedge clk);
        check("t3_no_phantom", busy, 0);
        // 4: asynchronous reset during RUN
        send(8'h33, 8'h44, 1'b0);
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("t4_busy", busy, 0);
        check("t4_in_ready", in_ready, 1);
        check("t4_out_valid", out_valid, 0);
        check("t4_sum", sum, 0);
        void'(q.pop_front());
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op("t4_next", 8'h01, 8'h01, 1'b0);
        // 6: signed overflow cases (expect 0 when the feature is disabled)
        run_op("t6a", 8'h7F, 8'h01, 1'b0);
        run_op("t6b", 8'h80, 8'hFF, 1'b0);
        run_op("t6c", 8'h10, 8'h20, 1'b0);
        // 5: random traffic with random handshakes
        issued = 0;
        done = 0;
        cycles = 0;
        while (done < 200 && cycles < 20000) begin
            @(negedge clk);
            cycles++;
            in_valid = (issued < 200) && ($urandom_range(0, 1) == 1);
            a = 8'($urandom);
            b = 8'($urandom);
            cin = 1'($urandom);
            out_ready = $urandom_range(0, 2) != 0;
            if (in_valid && in_ready) begin
                q.push_back(model(a, b, cin));
                issued++;
            end
            if (out_valid && out_ready) begin
                check_pop("t5");
                done++;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("t5_done", done, 200);
        check("t5_queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
